// File: rtl/q3_divider_if.sv
// q3_divider_if: Q2/Q3 -> divider request bundle and divider -> EX/MEM result
// bundle for the iterative RV32M divide unit.
//   start_i, funct3_i, op1_i, op2_i, reg_wr_port_i, flush_i : driven by pipeline
//   busy_o, done_o, result_o, reg_wr_port_o                  : driven by divider
// master = pipeline side, slave = divider side.
interface q3_divider_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      reg_wr_port_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      reg_wr_port_o;

    modport master (
        output start_i, funct3_i, op1_i, op2_i, reg_wr_port_i, flush_i,
        input  busy_o, done_o, result_o, reg_wr_port_o
    );

    modport slave (
        input  start_i, funct3_i, op1_i, op2_i, reg_wr_port_i, flush_i,
        output busy_o, done_o, result_o, reg_wr_port_o
    );
endinterface

// File: rtl/q3_divider.sv
// q3_divider: iterative restoring divider for DIV/DIVU/REM/REMU in Q3.
//   clk, rst : pipeline clock, synchronous active-high reset
//   bus      : q3_divider_if.slave
//     start_i/funct3_i/op1_i/op2_i/reg_wr_port_i : request from Q2/Q3
//     flush_i       : kill in-flight divide
//     busy_o        : stall request (combinational)
//     done_o        : one-cycle result pulse
//     result_o      : quotient or remainder (registered)
//     reg_wr_port_o : destination index of the completed divide (registered)
// One quotient bit per cycle, MSB first; divide-by-zero and signed overflow
// complete in a single cycle.
module q3_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    q3_divider_if.slave   bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e          state_q,   state_d;
    logic [XLEN-1:0] dvd_q,     dvd_d;      // dividend, shifts into quotient
    logic [XLEN-1:0] rem_q,     rem_d;
    logic [XLEN-1:0] dvs_q,     dvs_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic            qneg_q,    qneg_d;
    logic            rneg_q,    rneg_d;
    logic            is_rem_q,  is_rem_d;
    logic [4:0]      dst_q,     dst_d;
    logic [XLEN-1:0] result_q,  result_d;
    logic [4:0]      wr_port_q, wr_port_d;
    logic            done_q,    done_d;

    logic            start_ok;
    logic            in_signed;
    logic            in_rem;
    logic            op1_neg;
    logic            op2_neg;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div0;
    logic            ovf;
    logic [XLEN:0]   partial;
    logic            ge;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] min_int;

    assign min_int   = {1'b1, {(XLEN-1){1'b0}}};
    assign start_ok  = bus.start_i & ~bus.flush_i;
    // Anything other than DIV/REM/REMU decodes as DIVU.
    assign in_signed = (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
    assign in_rem    = (bus.funct3_i == 3'b110) || (bus.funct3_i == 3'b111);
    assign op1_neg   = in_signed & bus.op1_i[XLEN-1];
    assign op2_neg   = in_signed & bus.op2_i[XLEN-1];
    assign abs1      = op1_neg ? -bus.op1_i : bus.op1_i;
    assign abs2      = op2_neg ? -bus.op2_i : bus.op2_i;
    assign div0      = (bus.op2_i == '0);
    assign ovf       = in_signed && (bus.op1_i == min_int) && (bus.op2_i == '1);

    // Restoring step: remainder stays below divisor, so the difference
    // fits in XLEN bits whenever the subtract is taken.
    assign partial   = {rem_q, dvd_q[XLEN-1]};
    assign ge        = (partial >= {1'b0, dvs_q});
    assign rem_next  = ge ? (partial[XLEN-1:0] - dvs_q) : partial[XLEN-1:0];
    assign quo_next  = {dvd_q[XLEN-2:0], ge};

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        is_rem_d  = is_rem_q;
        dst_d     = dst_q;
        result_d  = result_q;
        wr_port_d = wr_port_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    dst_d    = bus.reg_wr_port_i;
                    is_rem_d = in_rem;
                    qneg_d   = op1_neg ^ op2_neg;
                    rneg_d   = op1_neg;
                    dvd_d    = abs1;
                    dvs_d    = abs2;
                    rem_d    = '0;
                    cnt_d    = CW'(XLEN - 1);
                    if (div0 || ovf) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        wr_port_d = bus.reg_wr_port_i;
                        if (div0)
                            result_d = in_rem ? bus.op1_i : '1;
                        else
                            result_d = in_rem ? '0 : min_int;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    dvd_d = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        wr_port_d = dst_q;
                        if (is_rem_q)
                            result_d = rneg_q ? -rem_next : rem_next;
                        else
                            result_d = qneg_q ? -quo_next : quo_next;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            is_rem_q  <= 1'b0;
            dst_q     <= '0;
            result_q  <= '0;
            wr_port_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            is_rem_q  <= is_rem_d;
            dst_q     <= dst_d;
            result_q  <= result_d;
            wr_port_q <= wr_port_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy_o        = ((state_q == IDLE) && start_ok) || (state_q == CALC);
    // done_q is high exactly in DONE; a flush in that cycle suppresses the pulse.
    assign bus.done_o        = done_q & ~bus.flush_i;
    assign bus.result_o      = result_q;
    assign bus.reg_wr_port_o = wr_port_q;
endmodule

// File: tb/tb_q3_divider.sv
// tb_q3_divider: self-checking bench for q3_divider. A cycle-level model
// derives busy/done/result/destination from the arithmetic definition of
// DIV/DIVU/REM/REMU and the stated latencies; a literal table pins the
// directed results and latencies.
module tb_q3_divider;
    localparam int unsigned XLEN = 32;
    localparam int NLIT = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    q3_divider_if #(.XLEN(XLEN)) bus ();
    q3_divider #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Directed completions in order: result, latency from acceptance, dst.
    logic [31:0] lit_res [NLIT] = '{32'd14, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1,
                                    32'hFFFFFFFF, 32'h00001234, 32'h80000000, 32'd0,
                                    32'd3, 32'd10, 32'd9};
    int          lit_lat [NLIT] = '{33, 33, 33, 33, 1, 1, 1, 1, 33, 33, 33};
    logic [4:0]  lit_dst [NLIT] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6,
                                    5'd7, 5'd8, 5'd9, 5'd10, 5'd11};

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        bit sgn;
        bit rm;
        sgn = (f3 == 3'b100) || (f3 == 3'b110);
        rm  = (f3 == 3'b110) || (f3 == 3'b111);
        if (b == 32'd0) return rm ? a : 32'hFFFFFFFF;
        if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return rm ? 32'd0 : 32'h80000000;
        if (sgn) return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return rm ? a % b : a / b;
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        bit sgn;
        sgn = (f3 == 3'b100) || (f3 == 3'b110);
        return (b == 32'd0) || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- compare process with model ----------------
    int          cyc = 0;
    bit          armed = 0;
    bit          m_active = 0;
    int          m_start_cyc = 0;
    int          m_done_cyc = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_dst = '0;
    logic [31:0] m_out_res = '0;
    logic [4:0]  m_out_dst = '0;
    int          li = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit exp_done;
        bit exp_busy;
        if (armed) begin
            exp_done = m_active && (cyc == m_done_cyc) && !bus.flush_i;
            exp_busy = m_active ? (cyc < m_done_cyc) : (bus.start_i && !bus.flush_i);
            if (m_active && cyc == m_done_cyc) begin
                m_out_res = m_res;
                m_out_dst = m_dst;
            end
            chk("busy", 32'(bus.busy_o), 32'(exp_busy));
            chk("done", 32'(bus.done_o), 32'(exp_done));
            chk("result", bus.result_o, m_out_res);
            chk("wr_port", 32'(bus.reg_wr_port_o), 32'(m_out_dst));
            if (exp_done && li < NLIT) begin
                chk("lit_result", bus.result_o, lit_res[li]);
                chk("lit_latency", 32'(cyc - m_start_cyc), 32'(lit_lat[li]));
                chk("lit_dst", 32'(bus.reg_wr_port_o), 32'(lit_dst[li]));
                li++;
            end
        end
        if (rst) begin
            armed     = 1;
            m_active  = 0;
            m_out_res = '0;
            m_out_dst = '0;
        end else if (m_active) begin
            if (bus.flush_i || cyc == m_done_cyc) m_active = 0;
        end else if (bus.start_i && !bus.flush_i) begin
            m_active    = 1;
            m_start_cyc = cyc;
            m_done_cyc  = cyc + (is_fast(bus.funct3_i, bus.op1_i, bus.op2_i) ? 1 : XLEN + 1);
            m_res       = ref_res(bus.funct3_i, bus.op1_i, bus.op2_i);
            m_dst       = bus.reg_wr_port_i;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        bus.funct3_i      = f3;
        bus.op1_i         = a;
        bus.op2_i         = b;
        bus.reg_wr_port_i = d;
        bus.start_i       = 1'b1;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input int lat);
        drive(f3, a, b, d);
        step(lat + 1);
        bus.start_i = 1'b0;
        step(2);
    endtask

    initial begin
        bus.start_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.funct3_i      = 3'b000;
        bus.op1_i         = '0;
        bus.op2_i         = '0;
        bus.reg_wr_port_i = '0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);

        run_op(3'b101, 32'd100,        32'd7,          5'd5, 33);
        run_op(3'b110, 32'hFFFFFFF9,   32'd2,          5'd1, 33);
        run_op(3'b100, 32'hFFFFFFF9,   32'd2,          5'd2, 33);
        run_op(3'b111, 32'hFFFFFFF9,   32'd2,          5'd3, 33);
        run_op(3'b100, 32'h00001234,   32'd0,          5'd4, 1);
        run_op(3'b110, 32'h00001234,   32'd0,          5'd6, 1);
        run_op(3'b100, 32'h80000000,   32'hFFFFFFFF,   5'd7, 1);
        run_op(3'b110, 32'h80000000,   32'hFFFFFFFF,   5'd8, 1);

        // Flush mid-CALC: no completion may follow.
        drive(3'b101, 32'd1000, 32'd3, 5'd20);
        step(10);
        bus.flush_i = 1'b1;
        step(1);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        step(40);
        run_op(3'b101, 32'd9, 32'd3, 5'd9, 33);

        // Back-to-back with start held across both instructions.
        drive(3'b101, 32'd50, 32'd5, 5'd10);
        step(34);
        drive(3'b101, 32'd81, 32'd9, 5'd11);
        step(34);
        bus.start_i = 1'b0;
        step(3);

        // Reset mid-CALC.
        drive(3'b101, 32'd12345, 32'd17, 5'd12);
        step(20);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.start_i = 1'b0;
        step(40);

        // Random phase: flush/reset/start in any state, mixed opcodes and corner operands.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.funct3_i      = 3'($urandom_range(0, 7));
                bus.op1_i         = rand_op();
                bus.op2_i         = rand_op();
                bus.reg_wr_port_i = 5'($urandom);
            end
            bus.start_i = ($urandom_range(0, 3) != 0);
            bus.flush_i = ($urandom_range(0, 63) == 0);
            rst         = ($urandom_range(0, 999) == 0);
            step(1);
        end
        rst         = 1'b0;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        step(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/q3_divider.md
Name: q3_divider

Overview:
- Iterative RV32M divide unit in the execute stage (Q3).
- Consumes the operand, destination and funct3 fields the ID/EX (Q2/Q3) pipeline register presents. Executes DIV, DIVU, REM and REMU.
- Asserts a stall request so the upstream pipeline registers hold the instruction in Q3 until the result is ready.
- Presents a one-cycle result pulse toward the EX/MEM register.

Parameters:
XLEN, 32, operand/result width; must be even and >= 4.

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  synchronous reset, active-high
start_i  input  1  Q3 holds a valid divide-class instruction (decoder M-ext divide control bit)
funct3_i  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes treated as DIVU
op1_i  input  XLEN  dividend (rs1 data from Q2/Q3)
op2_i  input  XLEN  divisor (rs2 data from Q2/Q3)
reg_wr_port_i  input  5  destination register index
flush_i  input  1  kill the in-flight divide (branch/trap redirect)
busy_o  output  1  stall request to PC and Q1/Q2, Q2/Q3 registers
done_o  output  1  result valid this cycle (single-cycle pulse)
result_o  output  XLEN  quotient or remainder
reg_wr_port_o  output  5  destination index captured at start

Behaviour:
- Reset: rst sampled high at clk edge -> state IDLE, all internal regs 0, done_o=0, result_o=0, reg_wr_port_o=0. busy_o=0 while in IDLE with start_i=0. rst overrides start_i and flush_i.
- States: IDLE, CALC, DONE.
- IDLE:
  - On start_i=1 and flush_i=0: latch op1_i, op2_i, funct3_i and reg_wr_port_i.
  - Signed ops (DIV, REM) convert both operands to absolute values; record quotient sign = sign(op1)^sign(op2) and remainder sign = sign(op1).
  - Divisor==0 -> DONE (fast path).
  - DIV/REM with op1=-2^(XLEN-1) and op2=-1 -> DONE (fast path).
  - Otherwise -> CALC with iteration counter = XLEN-1.
- CALC, restoring division, one quotient bit per cycle, MSB first:
  - Partial remainder (XLEN+1 bits) = {rem, next dividend bit}.
  - If partial >= divisor: subtract divisor and shift in 1; else shift in 0.
  - Counter decrements each cycle; after the iteration at counter 0 -> DONE. That is exactly XLEN CALC cycles.
- DONE:
  - done_o=1 for one cycle. result_o and reg_wr_port_o are registered values, stable only while done_o=1.
  - Unconditionally -> IDLE. start_i is ignored in DONE because the same instruction is still in Q3.
- busy_o, combinational:
  - 1 when (IDLE & start_i & ~flush_i) or CALC; 0 in DONE.
  - The pipeline therefore advances at the end of the DONE cycle.
- Result selection:
  - DIV/DIVU: quotient, negated if quotient sign set (signed ops only).
  - REM/REMU: remainder, negated if remainder sign set (signed ops only).
- Fast-path results:
  - Divisor 0: quotient = all ones; remainder = op1 unmodified, sign as given.
  - Overflow: quotient = -2^(XLEN-1); remainder = 0.
- Latency, start seen at cycle 0:
  - Normal: busy_o high cycles 0..XLEN, done_o at cycle XLEN+1.
  - Fast path: busy_o high cycle 0, done_o at cycle 1.
- Flush:
  - flush_i=1 in CALC or DONE -> IDLE next cycle.
  - done_o forced 0 in that cycle; result_o and reg_wr_port_o keep their previous values.
  - flush_i in IDLE blocks acceptance.
- Back-to-back: a new start_i is first sampled in the IDLE cycle after DONE, so there are no overlapping operations.
- Reset mid-CALC: the divide is abandoned, no done_o pulse, next start behaves as from power-up.
- Arithmetic: all intermediates use XLEN+1 bits; negation is two's complement, modulo 2^XLEN.

Test Plan:
- DIVU op1=100, op2=7, start at cycle 0 -> busy_o high cycles 0..32, done_o at cycle 33 only, result_o=14, reg_wr_port_o=captured index (e.g. 5).
- REM op1=-7 (0xFFFFFFF9), op2=2 -> result 0xFFFFFFFF (-1); DIV same operands -> 0xFFFFFFFD (-3); REMU 0xFFFFFFF9 % 2 -> 1.
- DIV op2=0, op1=0x1234 -> done_o at cycle 1, result 0xFFFFFFFF; REM same operands -> 0x00001234.
- DIV op1=0x80000000, op2=0xFFFFFFFF -> done_o at cycle 1, result 0x80000000; REM same operands -> 0.
- Start DIVU 1000/3, assert flush_i at cycle 10 -> IDLE at cycle 11, no done_o ever. Then start 9/3 -> result 3 at done_o.
- Two back-to-back DIVU (50/5 then 81/9, start_i held, operands switched after done_o) -> done_o pulses at cycles 33 and 67, results 10 and 9. Separately, rst at cycle 20 -> all outputs 0, no done_o.
